// File: rtl/mtl_frame_writer.sv
// mtl_frame_writer: streams one frame of pixels into the back buffer of a
// double-buffered SDRAM frame store. The front buffer changes only on a
// display end-of-frame pulse, and only after the whole frame has been written.
module mtl_frame_writer #(
    parameter int          H_PIX = 800,
    parameter int          V_PIX = 480,
    parameter logic [22:0] BASE0 = 23'h000000,
    parameter logic [22:0] BASE1 = 23'h080000
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [31:0] iPIX_DATA,
    input  logic        iPIX_VALID,
    input  logic        iPIX_SOF,
    output logic        oPIX_READY,
    output logic        oWR_REQ,
    output logic [22:0] oWR_ADDR,
    output logic [31:0] oWR_DATA,
    input  logic        iWR_ACK,
    input  logic        iEnd_Frame,
    output logic        oBUF_SEL,
    output logic        oFrame_Done,
    output logic        oSync_Err
);

    localparam logic [18:0] FRAME_PIX = 19'(H_PIX * V_PIX);

    typedef enum logic [1:0] {IDLE, WRITE, WAIT_SWAP} state_t;

    state_t      state;
    logic        holdValid;
    logic [22:0] holdAddr;
    logic [31:0] holdData;
    logic [18:0] pixCount;
    logic        bufSel;
    logic        frameDone;
    logic        syncErr;

    logic        pixReady;
    logic        xfer;
    logic        frameFull;
    logic        holdAck;
    logic [22:0] wrBase;
    logic [22:0] nextAddr;

    // The writer always fills the buffer the display is not reading.
    assign wrBase    = bufSel ? BASE0 : BASE1;
    assign frameFull = (pixCount == FRAME_PIX);
    assign holdAck   = holdValid && iWR_ACK;
    assign xfer      = iPIX_VALID && pixReady;
    // A first pixel (SOF, or any loaded pixel from IDLE) always lands at offset 0.
    assign nextAddr  = (iPIX_SOF || state == IDLE) ? wrBase : wrBase + 23'(pixCount);

    assign oWR_REQ     = holdValid;
    assign oWR_ADDR    = holdAddr;
    assign oWR_DATA    = holdData;
    assign oBUF_SEL    = bufSel;
    assign oFrame_Done = frameDone;
    assign oSync_Err   = syncErr;
    assign oPIX_READY  = pixReady;

    // Ready: a single holding slot, refilled in the same cycle it is acked.
    always_comb begin
        pixReady = 1'b0;
        if (!iRST) begin
            case (state)
                IDLE:      pixReady = 1'b1;
                WRITE:     pixReady = !frameFull && (!holdValid || iWR_ACK);
                default:   pixReady = 1'b0;
            endcase
        end
    end

    // Control FSM: frame sequencing, pixel count, buffer swap and status pulses.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state     <= IDLE;
            holdValid <= 1'b0;
            pixCount  <= '0;
            bufSel    <= 1'b0;
            frameDone <= 1'b0;
            syncErr   <= 1'b0;
        end else begin
            frameDone <= 1'b0;
            syncErr   <= 1'b0;
            if (holdAck) begin
                holdValid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (xfer) begin
                        if (iPIX_SOF) begin
                            holdValid <= 1'b1;
                            pixCount  <= 19'd1;
                            state     <= WRITE;
                        end else begin
                            syncErr <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (xfer) begin
                        holdValid <= 1'b1;
                        if (iPIX_SOF) begin
                            pixCount <= 19'd1;
                            syncErr  <= 1'b1;
                        end else begin
                            pixCount <= pixCount + 19'd1;
                        end
                    end else if (frameFull && holdAck) begin
                        state <= WAIT_SWAP;
                    end
                end
                WAIT_SWAP: begin
                    if (iEnd_Frame) begin
                        bufSel    <= !bufSel;
                        frameDone <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Holding register data path; contents are only meaningful while holdValid.
    always_ff @(posedge iCLK) begin
        if (xfer) begin
            holdAddr <= nextAddr;
            holdData <= iPIX_DATA;
        end
    end

endmodule

// File: tb/tb_mtl_frame_writer.sv
// Directed bench for mtl_frame_writer with a write scoreboard (4x2 frame).
module tb_mtl_frame_writer;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic [31:0] iPIX_DATA = '0;
    logic        iPIX_VALID = 1'b0;
    logic        iPIX_SOF = 1'b0;
    logic        oPIX_READY;
    logic        oWR_REQ;
    logic [22:0] oWR_ADDR;
    logic [31:0] oWR_DATA;
    logic        iWR_ACK = 1'b1;
    logic        iEnd_Frame = 1'b0;
    logic        oBUF_SEL;
    logic        oFrame_Done;
    logic        oSync_Err;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [22:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t sbQ[$];

    mtl_frame_writer #(.H_PIX(4), .V_PIX(2)) dut (
        .iCLK(iCLK), .iRST(iRST),
        .iPIX_DATA(iPIX_DATA), .iPIX_VALID(iPIX_VALID), .iPIX_SOF(iPIX_SOF),
        .oPIX_READY(oPIX_READY),
        .oWR_REQ(oWR_REQ), .oWR_ADDR(oWR_ADDR), .oWR_DATA(oWR_DATA), .iWR_ACK(iWR_ACK),
        .iEnd_Frame(iEnd_Frame), .oBUF_SEL(oBUF_SEL),
        .oFrame_Done(oFrame_Done), .oSync_Err(oSync_Err)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    // Offer one pixel; push its expected write once the DUT shows ready.
    task automatic sendPix(input logic [31:0] d, input logic sof, input logic [22:0] expAddr,
                           input logic expWrite, output int waited);
        wr_t e;
        waited = 0;
        iPIX_VALID = 1'b1;
        iPIX_DATA  = d;
        iPIX_SOF   = sof;
        forever begin
            @(negedge iCLK);
            if (oPIX_READY) break;
            waited++;
            if (waited > 50) begin
                check("ready_timeout", 32'(oPIX_READY), 32'd1);
                break;
            end
        end
        if (expWrite) begin
            e.addr = expAddr;
            e.data = d;
            sbQ.push_back(e);
        end
        tick();
        iPIX_VALID = 1'b0;
        iPIX_SOF   = 1'b0;
    endtask

    // Scoreboard: every acked write must match the oldest expected write.
    always @(negedge iCLK) begin
        wr_t e;
        if (!iRST && oWR_REQ && iWR_ACK) begin
            if (sbQ.size() == 0) begin
                check("unexpected_write_addr", 32'(oWR_ADDR), 32'hFFFF_FFFF);
            end else begin
                e = sbQ.pop_front();
                check("wr_addr", 32'(oWR_ADDR), 32'(e.addr));
                check("wr_data", oWR_DATA, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int waitSum;

        // Reset state
        repeat (2) @(posedge iCLK);
        @(negedge iCLK);
        check("rst_ready", 32'(oPIX_READY), 32'd0);
        check("rst_wr_req", 32'(oWR_REQ), 32'd0);
        check("rst_buf_sel", 32'(oBUF_SEL), 32'd0);
        check("rst_frame_done", 32'(oFrame_Done), 32'd0);
        check("rst_sync_err", 32'(oSync_Err), 32'd0);
        tick();
        iRST = 1'b0;

        // Frame 1 into buffer 1, ack tied high: one pixel per cycle
        waitSum = 0;
        for (int i = 0; i < 8; i++) begin
            sendPix(32'(i + 1), (i == 0), 23'h080000 + 23'(i), 1'b1, w);
            waitSum += w;
        end
        check("f1_no_stall", 32'(waitSum), 32'd0);
        @(negedge iCLK);
        check("f1_last_ready", 32'(oPIX_READY), 32'd0);
        tick();
        @(negedge iCLK);
        check("f1_wait_ready", 32'(oPIX_READY), 32'd0);
        check("f1_wait_req", 32'(oWR_REQ), 32'd0);
        check("f1_sb_empty", 32'(sbQ.size()), 32'd0);
        check("f1_no_swap_yet", 32'(oBUF_SEL), 32'd0);

        // Swap
        tick();
        iEnd_Frame = 1'b1;
        tick();
        iEnd_Frame = 1'b0;
        @(negedge iCLK);
        check("swap1_buf_sel", 32'(oBUF_SEL), 32'd1);
        check("swap1_done", 32'(oFrame_Done), 32'd1);
        @(negedge iCLK);
        check("swap1_done_1cyc", 32'(oFrame_Done), 32'd0);
        tick();

        // Frame 2 into buffer 0
        for (int i = 0; i < 8; i++) begin
            sendPix(32'h11 + 32'(i), (i == 0), 23'h000000 + 23'(i), 1'b1, w);
        end
        repeat (2) tick();
        check("f2_sb_empty", 32'(sbQ.size()), 32'd0);
        iEnd_Frame = 1'b1;
        tick();
        iEnd_Frame = 1'b0;
        @(negedge iCLK);
        check("swap2_buf_sel", 32'(oBUF_SEL), 32'd0);
        tick();

        // Frame 3: ack stall on pixel 2, then end-of-frame coincident with last ack
        for (int i = 0; i < 3; i++) begin
            sendPix(32'h21 + 32'(i), (i == 0), 23'h080000 + 23'(i), 1'b1, w);
        end
        iWR_ACK    = 1'b0;
        iPIX_VALID = 1'b1;
        iPIX_DATA  = 32'h24;
        for (int k = 0; k < 3; k++) begin
            @(negedge iCLK);
            check("stall_ready", 32'(oPIX_READY), 32'd0);
            check("stall_req", 32'(oWR_REQ), 32'd1);
            check("stall_addr", 32'(oWR_ADDR), 32'h080002);
            check("stall_data", oWR_DATA, 32'h23);
            tick();
        end
        iWR_ACK = 1'b1;
        for (int i = 3; i < 8; i++) begin
            sendPix(32'h21 + 32'(i), 1'b0, 23'h080000 + 23'(i), 1'b1, w);
        end
        iEnd_Frame = 1'b1;
        @(negedge iCLK);
        check("last_ack_req", 32'(oWR_REQ), 32'd1);
        tick();
        iEnd_Frame = 1'b0;
        @(negedge iCLK);
        check("coinc_no_swap", 32'(oBUF_SEL), 32'd0);
        check("coinc_no_done", 32'(oFrame_Done), 32'd0);
        check("coinc_wait_req", 32'(oWR_REQ), 32'd0);
        check("f3_sb_empty", 32'(sbQ.size()), 32'd0);
        repeat (2) tick();
        iEnd_Frame = 1'b1;
        tick();
        iEnd_Frame = 1'b0;
        @(negedge iCLK);
        check("late_swap_buf_sel", 32'(oBUF_SEL), 32'd1);
        check("late_swap_done", 32'(oFrame_Done), 32'd1);
        tick();

        // Reset while a write is pending
        iWR_ACK = 1'b0;
        sendPix(32'hA1, 1'b1, 23'h0, 1'b0, w);
        @(negedge iCLK);
        check("pre_rst_req", 32'(oWR_REQ), 32'd1);
        tick();
        iRST = 1'b1;
        tick();
        iRST = 1'b0;
        @(negedge iCLK);
        check("post_rst_req", 32'(oWR_REQ), 32'd0);
        check("post_rst_buf_sel", 32'(oBUF_SEL), 32'd0);
        tick();
        iWR_ACK = 1'b1;

        // Pixel without SOF in IDLE is dropped
        sendPix(32'hB0, 1'b0, 23'h0, 1'b0, w);
        @(negedge iCLK);
        check("drop_sync_err", 32'(oSync_Err), 32'd1);
        check("drop_no_req", 32'(oWR_REQ), 32'd0);
        @(negedge iCLK);
        check("drop_sync_err_1cyc", 32'(oSync_Err), 32'd0);
        tick();

        // SOF on pixel 5 restarts the frame at offset 0
        for (int i = 0; i < 5; i++) begin
            sendPix(32'h31 + 32'(i), (i == 0), 23'h080000 + 23'(i), 1'b1, w);
        end
        @(negedge iCLK);
        check("no_restart_err", 32'(oSync_Err), 32'd0);
        tick();
        sendPix(32'h41, 1'b1, 23'h080000, 1'b1, w);
        @(negedge iCLK);
        check("restart_sync_err", 32'(oSync_Err), 32'd1);
        tick();
        for (int i = 1; i < 8; i++) begin
            sendPix(32'h41 + 32'(i), 1'b0, 23'h080000 + 23'(i), 1'b1, w);
        end
        repeat (2) tick();
        @(negedge iCLK);
        check("f4_wait_ready", 32'(oPIX_READY), 32'd0);
        check("f4_sb_empty", 32'(sbQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
